// File: rtl/jtframe_ba_rom_mux_if.sv
// jtframe_ba_rom_mux_if: read-only bank port between the ROM mux and jtframe_sdram64
interface jtframe_ba_rom_mux_if;
  logic [21:0] ba_addr;
  logic        ba_rd;
  logic        ba_ack;
  logic        ba_dst;
  logic        ba_dok;
  logic        ba_rdy;
  logic [15:0] data_read;
  modport master (output ba_addr, ba_rd, input ba_ack, ba_dst, ba_dok, ba_rdy, data_read);
  modport slave  (input ba_addr, ba_rd, output ba_ack, ba_dst, ba_dok, ba_rdy, data_read);
endinterface

// File: rtl/jtframe_ba_rom_mux.sv
// jtframe_ba_rom_mux: round-robin arbiter sharing one SDRAM bank among cached ROM read clients
module jtframe_ba_rom_mux #(
  parameter int CLIENTS = 4,
  parameter int AW = 22,
  parameter int DW = 16,
  parameter logic [AW-1:0] OFFSET = '0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CLIENTS-1:0]    cl_req,
  input  logic [CLIENTS*AW-1:0] cl_addr,
  output logic [CLIENTS-1:0]    cl_ok,
  output logic [CLIENTS*DW-1:0] cl_dout,
  jtframe_ba_rom_mux_if.master  ba,
  output logic                  busy
);
  localparam int BURST = DW / 16;
  localparam int CW = $clog2(BURST + 1);
  localparam int GW = $clog2(CLIENTS);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
  state_t state;
  logic [AW-1:0] lat_addr [CLIENTS];
  logic [DW-1:0] data [CLIENTS];
  logic [CLIENTS-1:0] valid, pending;
  logic [GW-1:0] ptr, gnt, sel, c;
  logic found;
  logic [CW-1:0] cnt;
  logic [AW-1:0] sel_addr;
  function automatic int rr(input logic [GW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return s >= CLIENTS ? s - CLIENTS : s;
  endfunction
  for (genvar i = 0; i < CLIENTS; i++) begin : g_cl
    assign cl_ok[i] = cl_req[i] & valid[i] & (cl_addr[i*AW +: AW] == lat_addr[i]);
    assign cl_dout[i*DW +: DW] = data[i];
  end
  assign pending = cl_req & ~cl_ok;
  assign sel_addr = cl_addr[sel*AW +: AW];
  // first pending client at or after ptr, wrapping
  always_comb begin
    sel = ptr;
    found = 1'b0;
    c = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      c = GW'(rr(ptr, k));
      if (!found && pending[c]) begin
        sel = c;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ba.ba_rd <= 1'b0;
      ba.ba_addr <= '0;
      busy <= 1'b0;
      ptr <= '0;
      gnt <= '0;
      cnt <= '0;
      valid <= '0;
      for (int i = 0; i < CLIENTS; i++) begin
        lat_addr[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt <= sel;
          lat_addr[sel] <= sel_addr;
          valid[sel] <= 1'b0;
          ba.ba_addr <= 22'(sel_addr + OFFSET);
          ba.ba_rd <= 1'b1;
          busy <= 1'b1;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (ba.ba_ack) begin
          ba.ba_rd <= 1'b0;
          cnt <= '0;
          state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          // words beyond the burst length are dropped; a short burst leaves old halves intact
          if (ba.ba_dok && int'(cnt) < BURST) begin
            for (int w = 0; w < BURST; w++)
              if (int'(cnt) == w) data[gnt][w*16 +: 16] <= ba.data_read;
            cnt <= cnt + 1'b1;
          end
          if (ba.ba_rdy) begin
            valid[gnt] <= 1'b1;
            ptr <= (gnt == GW'(CLIENTS - 1)) ? '0 : gnt + 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtframe_ba_rom_mux.sv
// tb_jtframe_ba_rom_mux: directed checks of a 16-bit mux and a 32-bit offset mux sharing one controller model
module tb_jtframe_ba_rom_mux;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] req_a = '0, req_b = '0;
  logic [4*22-1:0] addr = '0;
  logic ack = 1'b0, dst = 1'b0, dok = 1'b0, rdy = 1'b0;
  logic [15:0] din = '0;
  logic [3:0] ok_a, ok_b;
  logic busy_a, busy_b;
  logic [63:0] dout_a;
  logic [127:0] dout_b;
  int checks = 0, errors = 0;
  jtframe_ba_rom_mux_if ba_a ();
  jtframe_ba_rom_mux_if ba_b ();
  assign ba_a.ba_ack = ack;
  assign ba_a.ba_dst = dst;
  assign ba_a.ba_dok = dok;
  assign ba_a.ba_rdy = rdy;
  assign ba_a.data_read = din;
  assign ba_b.ba_ack = ack;
  assign ba_b.ba_dst = dst;
  assign ba_b.ba_dok = dok;
  assign ba_b.ba_rdy = rdy;
  assign ba_b.data_read = din;
  jtframe_ba_rom_mux #(.CLIENTS(4), .AW(22), .DW(16), .OFFSET(22'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .cl_req(req_a), .cl_addr(addr), .cl_ok(ok_a),
    .cl_dout(dout_a), .ba(ba_a), .busy(busy_a));
  jtframe_ba_rom_mux #(.CLIENTS(4), .AW(22), .DW(32), .OFFSET(22'h100000)) dut_b (
    .clk(clk), .rst_n(rst_n), .cl_req(req_b), .cl_addr(addr), .cl_ok(ok_b),
    .cl_dout(dout_b), .ba(ba_b), .busy(busy_b));
  typedef struct {
    logic [3:0]  req;
    logic        ack, dst, dok, rdy;
    logic [15:0] d;
    logic        rd;
    logic [21:0] a;
    logic        bsy;
    logic [3:0]  ok;
  } vec_t;
  vec_t tv [8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic set_addr(input int i, input logic [21:0] a);
    addr[i*22 +: 22] = a;
  endtask
  task automatic serve_a(input logic [15:0] d, output logic [21:0] got);
    int n;
    n = 0;
    while (!ba_a.ba_rd && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", ba_a.ba_rd, 1);
    got = ba_a.ba_addr;
    ack = 1; tick(); ack = 0;
    dok = 1; rdy = 1; din = d; tick(); dok = 0; rdy = 0;
  endtask
  initial begin
    logic [21:0] got;
    logic [21:0] rr_exp [5];
    tv[0] = '{4'b0100, 0, 0, 0, 0, 16'h0000, 1, 22'h1234, 1, 4'b0000};
    tv[1] = '{4'b0100, 0, 0, 0, 0, 16'h0000, 1, 22'h1234, 1, 4'b0000};
    tv[2] = '{4'b0100, 0, 0, 0, 0, 16'h0000, 1, 22'h1234, 1, 4'b0000};
    tv[3] = '{4'b0100, 1, 0, 0, 0, 16'h0000, 0, 22'h1234, 1, 4'b0000};
    tv[4] = '{4'b0100, 0, 1, 0, 0, 16'h0000, 0, 22'h1234, 1, 4'b0000};
    tv[5] = '{4'b0100, 0, 0, 1, 1, 16'hBEEF, 0, 22'h1234, 0, 4'b0100};
    tv[6] = '{4'b0100, 0, 0, 0, 0, 16'h0000, 0, 22'h1234, 0, 4'b0100};
    tv[7] = '{4'b0000, 0, 0, 0, 0, 16'h0000, 0, 22'h1234, 0, 4'b0000};
    rr_exp = '{22'h100, 22'h101, 22'h102, 22'h103, 22'h200};
    tick(); tick();
    chk("rst_rd_a", ba_a.ba_rd, 0);
    chk("rst_addr_a", ba_a.ba_addr, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_rd_b", ba_b.ba_rd, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1;
    tick();
    // single 16-bit read by client 2
    set_addr(2, 22'h1234);
    for (int v = 0; v < 8; v++) begin
      req_a = tv[v].req; ack = tv[v].ack; dst = tv[v].dst;
      dok = tv[v].dok; rdy = tv[v].rdy; din = tv[v].d;
      tick();
      chk($sformatf("t1_rd[%0d]", v), ba_a.ba_rd, tv[v].rd);
      chk($sformatf("t1_addr[%0d]", v), ba_a.ba_addr, tv[v].a);
      chk($sformatf("t1_busy[%0d]", v), busy_a, tv[v].bsy);
      chk($sformatf("t1_ok[%0d]", v), ok_a, tv[v].ok);
    end
    ack = 0; dst = 0; dok = 0; rdy = 0;
    chk("t1_dout2", dout_a[47:32], 16'hBEEF);
    // 32-bit burst on the offset instance, client 0
    set_addr(0, 22'h10);
    req_b = 4'b0001;
    tick();
    chk("t2_rd", ba_b.ba_rd, 1);
    chk("t2_addr", ba_b.ba_addr, 22'h100010);
    ack = 1; tick(); ack = 0;
    dok = 1; din = 16'hAAAA; tick(); dok = 0;
    chk("t2_ok_mid", ok_b, 4'b0000);
    chk("t2_busy_mid", busy_b, 1);
    dok = 1; rdy = 1; din = 16'h5555; tick(); dok = 0; rdy = 0;
    chk("t2_ok", ok_b, 4'b0001);
    chk("t2_dout0", dout_b[31:0], 32'h5555AAAA);
    // offset addition, client 3
    set_addr(3, 22'h0FF);
    req_b = 4'b1001;
    tick();
    chk("t5_rd", ba_b.ba_rd, 1);
    chk("t5_addr", ba_b.ba_addr, 22'h1000FF);
    ack = 1; tick(); ack = 0;
    dok = 1; din = 16'h1111; tick();
    rdy = 1; din = 16'h2222; tick(); dok = 0; rdy = 0;
    chk("t5_ok", ok_b, 4'b1001);
    chk("t5_dout3", dout_b[127:96], 32'h22221111);
    req_b = 0;
    // round robin from reset
    rst_n = 0; tick(); rst_n = 1;
    for (int i = 0; i < 4; i++) set_addr(i, 22'h100 + 22'(i));
    req_a = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      serve_a(16'h0A00 + 16'(g), got);
      chk($sformatf("t3_grant[%0d]", g), got, rr_exp[g]);
      if (g == 0) set_addr(0, 22'h200);
    end
    chk("t3_ok_all", ok_a, 4'b1111);
    // address change while data is in flight
    req_a = 4'b0010;
    set_addr(1, 22'h20);
    tick();
    chk("t4_rd", ba_a.ba_rd, 1);
    chk("t4_addr", ba_a.ba_addr, 22'h20);
    ack = 1; tick(); ack = 0;
    set_addr(1, 22'h21);
    dok = 1; rdy = 1; din = 16'h2020; tick(); dok = 0; rdy = 0;
    chk("t4_ok_stale", ok_a[1], 0);
    chk("t4_dout1", dout_a[31:16], 16'h2020);
    tick();
    chk("t4_rd2", ba_a.ba_rd, 1);
    chk("t4_addr2", ba_a.ba_addr, 22'h21);
    serve_a(16'h2121, got);
    chk("t4_ok_new", ok_a[1], 1);
    // reset mid-burst
    req_a = 4'b0001;
    set_addr(0, 22'h300);
    tick();
    chk("t6_rd", ba_a.ba_rd, 1);
    ack = 1; tick(); ack = 0;
    dok = 1; din = 16'h1111; tick(); dok = 0;
    rst_n = 0;
    #1;
    chk("t6_rd_rst", ba_a.ba_rd, 0);
    chk("t6_busy_rst", busy_a, 0);
    chk("t6_ok_rst", ok_a, 4'b0000);
    tick();
    rst_n = 1;
    dok = 1; rdy = 1; din = 16'hDEAD; tick(); dok = 0; rdy = 0;
    chk("t6_ok_stray", ok_a, 4'b0000);
    chk("t6_dout_stray", dout_a[15:0], 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
